wptr_full_ctrl: RTL and testbench

- Write-domain pointer and flag controller that feeds the dual-clock FIFO memory stage: drives its write address and full flag.
- Keeps the binary and Gray write pointers and compares against the read pointer already synchronised into wclk.
- Also produces an almost-full flag, an occupancy count and a sticky overflow flag for upstream producers.

---
 rtl/wptr_full_ctrl.sv | 54 +++++
 tb/tb_wptr_full_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer, full/almost-full, occupancy and overflow control for a dual-clock FIFO
module wptr_full_ctrl #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);
  localparam int W = ADDRSIZE + 1;
  logic [W-1:0] wbin_q, wbin_d, wptr_q, wptr_d, level_q, level_d, rbin_s;
  logic wfull_q, wfull_d, awfull_q, awfull_d, ovf_q, ovf_d;
  always_comb begin
    wbin_d = wbin_q + W'(winc & ~wfull_q);
    wptr_d = (wbin_d >> 1) ^ wbin_d;
    for (int i = 0; i < W; i++) rbin_s[i] = ^(wq2_rptr >> i);
    level_d = wbin_d - rbin_s;
    wfull_d = wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    awfull_d = level_d >= W'(AFULL_LEVEL);
    // a write attempt while full outranks a simultaneous clear
    ovf_d = (winc & wfull_q) | (ovf_q & ~wclr_ovf);
  end
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      ovf_q    <= ovf_d;
    end
  end
  assign waddr     = wbin_q[ADDRSIZE-1:0];
  assign wptr      = wptr_q;
  assign wfull     = wfull_q;
  assign awfull    = awfull_q;
  assign wlevel    = level_q;
  assign woverflow = ovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed self-checking bench for wptr_full_ctrl (ADDRSIZE=4, AFULL_LEVEL=12)
module tb_wptr_full_ctrl;
  logic wclk = 1'b0, wrst = 1'b1, winc = 1'b0, wclr_ovf = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel, prev;
  logic wfull, awfull, woverflow, seen;
  int checks = 0, failures = 0, w;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_LEVEL(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .awfull(awfull), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input int x);
    logic [4:0] b;
    b = x[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wptr"}, 32'(wptr), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".awfull"}, 32'(awfull), 0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".woverflow"}, 32'(woverflow), 0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    tick();
    tick();
    wrst = 1'b0;
    // fill
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      chk("fill.waddr", 32'(waddr), i);
      tick();
      chk("fill.wlevel", 32'(wlevel), i + 1);
      chk("fill.awfull", 32'(awfull), 32'(i + 1 >= 12));
      chk("fill.wfull", 32'(wfull), 32'(i == 15));
    end
    chk("fill.wptr", 32'(wptr), 5'b11000);
    // overflow
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf.wptr", 32'(wptr), 5'b11000);
      chk("ovf.flag", 32'(woverflow), 1);
      chk("ovf.wfull", 32'(wfull), 1);
    end
    winc = 1'b0;
    wclr_ovf = 1'b1;
    tick();
    chk("ovf.clear", 32'(woverflow), 0);
    winc = 1'b1;
    tick();
    chk("ovf.set_wins", 32'(woverflow), 1);
    winc = 1'b0;
    wclr_ovf = 1'b0;
    // drain from full
    wq2_rptr = 5'b00110;
    tick();
    chk("drain4.wfull", 32'(wfull), 0);
    chk("drain4.wlevel", 32'(wlevel), 12);
    chk("drain4.awfull", 32'(awfull), 1);
    wq2_rptr = 5'b00111;
    tick();
    chk("drain5.wlevel", 32'(wlevel), 11);
    chk("drain5.awfull", 32'(awfull), 0);
    chk("drain5.wptr", 32'(wptr), 5'b11000);
    // refill to full then race a dropped write against a read advance
    winc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("refill.wfull", 32'(wfull), 1);
    chk("refill.wlevel", 32'(wlevel), 16);
    wq2_rptr = gray(6);
    tick();
    winc = 1'b0;
    chk("race.wfull", 32'(wfull), 0);
    chk("race.wlevel", 32'(wlevel), 15);
    chk("race.ovf", 32'(woverflow), 1);
    chk("race.wptr", 32'(wptr), 5'b11111);
    // reset mid-burst
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    wq2_rptr = '0;
    winc = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("burst.waddr", 32'(waddr), 7);
    #2 wrst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    chk_zero("midrst_hold");
    wrst = 1'b0;
    chk("post.waddr0", 32'(waddr), 0);
    tick();
    chk("post.wlevel", 32'(wlevel), 1);
    chk("post.waddr1", 32'(waddr), 1);
    // steady-state wrap at occupancy 3
    tick();
    tick();
    chk("steady.start", 32'(wlevel), 3);
    w = 3;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = gray(w + 1 - 3);
      prev = wptr;
      tick();
      w++;
      chk("steady.wlevel", 32'(wlevel), 3);
      chk("steady.wfull", 32'(wfull), 0);
      chk("steady.awfull", 32'(awfull), 0);
      chk("steady.wptr", 32'(wptr), 32'(gray(w)));
      chk("steady.onebit", $countones(prev ^ wptr), 1);
      if (prev == 5'b10000 && wptr == 5'b00000) seen = 1'b1;
    end
    chk("steady.wrap_seen", 32'(seen), 1);
    winc = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
